uart_digest_sender: RTL and testbench
=====================================

UART_DIGEST_SENDER -- requirements
Module: uart_digest_sender

Interface
REQ-001 Parameter UART_DATA_WIDTH, default 8, byte width driven to the UART transmitter.
REQ-002 Parameter DIGEST_WIDTH, default 256, digest width; SHALL be a multiple of 8 (NBYTES = DIGEST_WIDTH/8).
REQ-003 Parameter SOF_BYTE, default 8'hA5, start-of-frame byte.
REQ-004 i_Clock  in  1  single clock; all logic on rising edge.
REQ-005 i_Reset  in  1  synchronous, active-high reset.
REQ-006 i_Start  in  1  frame request; sampled only in IDLE.
REQ-007 i_Digest  in  DIGEST_WIDTH  digest to send; captured on accept.
REQ-008 o_Busy  out  1  high from cycle after accept until FINISH exits.
REQ-009 o_Done  out  1  one-cycle pulse after the last byte completes.
REQ-010 o_Tx_DV  out  1  one-cycle byte-valid pulse to the UART transmitter.
REQ-011 o_Tx_Byte  out  UART_DATA_WIDTH  byte to the UART transmitter.
REQ-012 i_Tx_Active  in  1  UART transmitter busy.
REQ-013 i_Tx_Done  in  1  UART transmitter completion; level may stay high up to 3 cycles per byte.

Function
REQ-014 Frame SHALL be NBYTES+2 bytes: index 0 = SOF_BYTE; 1..NBYTES = digest bytes MSB first (index 1 = i_Digest[DIGEST_WIDTH-1 -: 8]); NBYTES+1 = XOR of all digest bytes.
REQ-015 States SHALL be IDLE, SEND, WAIT, FINISH; undefined encodings SHALL go to IDLE.
REQ-016 IDLE: i_Start=1 -> capture i_Digest into a shift register, clear byte index and checksum, go to SEND; else stay.
REQ-017 SEND: when i_Tx_Active=0 and i_Tx_Done=0, drive o_Tx_DV=1 for exactly one cycle with o_Tx_Byte = current frame byte, go to WAIT; otherwise hold with o_Tx_DV=0.
REQ-018 WAIT: on rising edge of i_Tx_Done (current 1, registered previous 0): if index < NBYTES+1, increment index and go to SEND; else go to FINISH. A sustained high level SHALL count as one completion.
REQ-019 FINISH: o_Done=1 for one cycle, o_Busy=0 from the next cycle, go to IDLE.
REQ-020 Checksum SHALL XOR each digest byte as its o_Tx_DV issues; the checksum byte SHALL equal the XOR of the captured digest bytes.
REQ-021 o_Tx_DV, o_Tx_Byte, o_Busy, o_Done SHALL be registered; o_Tx_Byte SHALL hold stable from its DV cycle until that byte's i_Tx_Done rising edge.
REQ-022 Latency: Start accepted at cycle T -> o_Busy=1 at T+1, first o_Tx_DV no earlier than T+2 (exactly T+2 if UART idle).
REQ-023 Inter-byte gap: i_Tx_Done rising edge at C -> next o_Tx_DV at C+2 once UART idle.
REQ-024 i_Start while not IDLE SHALL be ignored; i_Digest changes after accept SHALL not affect the frame.
REQ-025 i_Start held high SHALL start a new frame in the IDLE cycle after FINISH.
REQ-026 Exactly NBYTES+2 o_Tx_DV pulses per accepted frame; no DV in IDLE or FINISH.

Reset
REQ-027 i_Reset=1 SHALL force state IDLE, index 0, checksum 0, digest register 0, Tx_Done edge register 0, o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Done=0 at the next edge.
REQ-028 Reset mid-frame SHALL abort with no further DV; a byte already in the UART completes; the next frame waits per REQ-017 for i_Tx_Active=0 and i_Tx_Done=0.
REQ-029 i_Reset SHALL take priority over i_Start in the same cycle.

Verification
REQ-030 Reset: hold i_Reset 2 cycles with i_Start=1 -> all outputs 0, no DV, state IDLE.
REQ-031 Frame, paired with uart_tx at 104 config: i_Digest = bytes 0x00..0x1F ascending -> DV bytes A5, 00..1F, 00; 34 DV pulses; one o_Done pulse.
REQ-032 Checksum: i_Digest[255:248]=0x5A, rest 0 -> bytes A5, 5A, 31x 00, 5A.
REQ-033 Start mid-frame with a different digest and i_Digest change after accept -> ignored; transmitted bytes match captured digest.
REQ-034 Reset 1 cycle after 6th DV -> o_Busy=0, no DV; i_Start immediately -> first DV only after i_Tx_Active=0 and i_Tx_Done=0, frame restarts at A5.
REQ-035 i_Start held high, i_Tx_Done from a model held high 3 cycles per byte -> back-to-back frames, 34 DV per frame, no skipped or duplicated byte.

Source files
------------

// File: rtl/uart_digest_sender.sv
// Streams a digest to a byte-wide UART transmitter as a framed packet:
// start-of-frame byte, digest bytes MSB first, then an XOR checksum byte.
module uart_digest_sender #(
    parameter int unsigned UART_DATA_WIDTH = 8,
    parameter int unsigned DIGEST_WIDTH    = 256,
    parameter logic [7:0]  SOF_BYTE        = 8'hA5
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Start,
    input  logic [DIGEST_WIDTH-1:0]    i_Digest,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic                       o_Tx_DV,
    output logic [UART_DATA_WIDTH-1:0] o_Tx_Byte,
    input  logic                       i_Tx_Active,
    input  logic                       i_Tx_Done
);

    localparam int unsigned NBYTES   = DIGEST_WIDTH / 8;
    localparam int unsigned LAST_IDX = NBYTES + 1;
    localparam int unsigned IDX_W    = $clog2(NBYTES + 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [DIGEST_WIDTH-1:0]    digest_q, digest_d;
    logic [IDX_W-1:0]           index_q, index_d;
    logic [7:0]                 csum_q, csum_d;
    logic                       tx_done_prev_q, tx_done_prev_d;
    logic                       tx_dv_q, tx_dv_d;
    logic [UART_DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [7:0]                 frame_byte_c;
    logic                       is_digest_idx_c;
    logic                       tx_done_rise_c;
    logic                       uart_idle_c;

    // Byte at the current frame position; the digest register shifts so its top byte is always next.
    always_comb begin
        is_digest_idx_c = (index_q != '0) && (index_q != IDX_W'(LAST_IDX));
        if (index_q == '0) begin
            frame_byte_c = SOF_BYTE;
        end else if (index_q == IDX_W'(LAST_IDX)) begin
            frame_byte_c = csum_q;
        end else begin
            frame_byte_c = digest_q[DIGEST_WIDTH-1 -: 8];
        end
    end

    assign tx_done_rise_c = i_Tx_Done && !tx_done_prev_q;
    assign uart_idle_c    = !i_Tx_Active && !i_Tx_Done;

    always_comb begin
        state_d        = state_q;
        digest_d       = digest_q;
        index_d        = index_q;
        csum_d         = csum_q;
        tx_done_prev_d = i_Tx_Done;
        tx_dv_d        = 1'b0;
        tx_byte_d      = tx_byte_q;
        busy_d         = busy_q;
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    digest_d = i_Digest;
                    index_d  = '0;
                    csum_d   = 8'h00;
                    busy_d   = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (uart_idle_c) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = UART_DATA_WIDTH'(frame_byte_c);
                    if (is_digest_idx_c) begin
                        csum_d   = csum_q ^ frame_byte_c;
                        digest_d = digest_q << 8;
                    end
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A level held high for several cycles is one completion.
                if (tx_done_rise_c) begin
                    if (index_q < IDX_W'(LAST_IDX)) begin
                        index_d = index_q + 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q        <= ST_IDLE;
            digest_q       <= '0;
            index_q        <= '0;
            csum_q         <= 8'h00;
            tx_done_prev_q <= 1'b0;
            tx_dv_q        <= 1'b0;
            tx_byte_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            digest_q       <= digest_d;
            index_q        <= index_d;
            csum_q         <= csum_d;
            tx_done_prev_q <= tx_done_prev_d;
            tx_dv_q        <= tx_dv_d;
            tx_byte_q      <= tx_byte_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign o_Busy    = busy_q;
    assign o_Done    = done_q;
    assign o_Tx_DV   = tx_dv_q;
    assign o_Tx_Byte = tx_byte_q;

endmodule

// File: tb/tb_uart_digest_sender.sv
// Bench for uart_digest_sender: a UART stand-in answers each byte with an
// active period and a done level, while a frame-level scoreboard checks bytes.
module tb_uart_digest_sender;

    localparam int unsigned DW        = 256;
    localparam int unsigned NB        = DW / 8;
    localparam int unsigned FRAME_LEN = NB + 2;
    localparam logic [7:0]  SOF       = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b1;
    logic [DW-1:0] digest = '0;
    logic          busy;
    logic          done;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_active = 1'b0;
    logic          tx_done = 1'b0;

    always #5 clk = ~clk;

    uart_digest_sender #(
        .UART_DATA_WIDTH(8),
        .DIGEST_WIDTH   (DW),
        .SOF_BYTE       (SOF)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Start    (start),
        .i_Digest   (digest),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Tx_DV    (tx_dv),
        .o_Tx_Byte  (tx_byte),
        .i_Tx_Active(tx_active),
        .i_Tx_Done  (tx_done)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte = 8'h00;
    logic [7:0] mon_e;
    int         dv_cnt = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    int         act_min = 1, act_max = 3, done_min = 1, done_max = 1;
    int         act_left = 0, done_left = 0;
    bit         gap_chk = 1'b0, have_rise = 1'b0;
    int         rise_cyc = 0;
    logic       done_prev = 1'b0;

    // Monitor and UART stand-in; inputs read here are the values the DUT sampled at the last edge.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (tx_dv === 1'b1) begin
                dv_cnt++;
                checks++;
                if (tx_active !== 1'b0 || tx_done !== 1'b0) begin
                    errors++;
                    $display("FAIL dv_while_uart_busy: active=%b done=%b required 0 0", tx_active, tx_done);
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL dv_without_busy: busy=%b required 1", busy);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_dv: byte=%h required no DV", tx_byte);
                    exp_byte = tx_byte;
                end else begin
                    mon_e = exp_q.pop_front();
                    if (tx_byte !== mon_e) begin
                        errors++;
                        $display("FAIL dv_byte: byte=%h required %h", tx_byte, mon_e);
                    end
                    exp_byte = mon_e;
                end
                if (gap_chk && have_rise) begin
                    checks++;
                    if (cyc != rise_cyc + 2) begin
                        errors++;
                        $display("FAIL inter_byte_gap: dv at +%0d required +2", cyc - rise_cyc);
                    end
                end
                have_rise = 1'b0;
            end else begin
                if (rst) exp_byte = 8'h00;
                checks++;
                if (tx_byte !== exp_byte) begin
                    errors++;
                    $display("FAIL byte_hold: byte=%h required %h", tx_byte, exp_byte);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                have_rise = 1'b0;
            end
            if (rst) have_rise = 1'b0;
        end

        if (tx_dv === 1'b1) begin
            act_left  = $urandom_range(act_max, act_min);
            done_left = $urandom_range(done_max, done_min);
        end
        if (act_left > 0) begin
            tx_active = 1'b1;
            tx_done   = 1'b0;
            act_left--;
        end else if (done_left > 0) begin
            tx_active = 1'b0;
            tx_done   = 1'b1;
            done_left--;
        end else begin
            tx_active = 1'b0;
            tx_done   = 1'b0;
        end
        if (tx_done && !done_prev) begin
            rise_cyc  = cyc;
            have_rise = 1'b1;
        end
        done_prev = tx_done;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_digest();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Reference frame: SOF, digest bytes MSB first, XOR of the digest bytes.
    function automatic void push_frame(input logic [DW-1:0] d);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        exp_q.push_back(SOF);
        for (int i = NB - 1; i >= 0; i--) begin
            b = d[i*8 +: 8];
            exp_q.push_back(b);
            x = x ^ b;
        end
        exp_q.push_back(x);
    endfunction

    task automatic wait_uart_idle();
        int n = 0;
        while ((act_left > 0 || done_left > 0 || tx_active || tx_done) && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: done pulses=%0d required %0d", name, done_cnt, target);
        end
    endtask

    task automatic finish_frames(input int dv0, input int dn0, input int nframes, input string name);
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after_finish: busy=%b required 0", name, busy);
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_bytes: left=%0d required 0", name, exp_q.size());
        end
        checks++;
        if (dv_cnt - dv0 != nframes * FRAME_LEN) begin
            errors++;
            $display("FAIL %s_dv_count: dv=%0d required %0d", name, dv_cnt - dv0, nframes * FRAME_LEN);
        end
        checks++;
        if (done_cnt - dn0 != nframes) begin
            errors++;
            $display("FAIL %s_done_count: done=%0d required %0d", name, done_cnt - dn0, nframes);
        end
        exp_q.delete();
        wait_uart_idle();
    endtask

    // One frame; with noise, stray starts and digest changes are driven while it is in flight.
    task automatic run_frame(input logic [DW-1:0] d, input bit noise, input string name);
        int dv0 = dv_cnt;
        int dn0 = done_cnt;
        int n = 0;
        push_frame(d);
        digest = d;
        start  = 1'b1;
        step();
        start  = 1'b0;
        while (done_cnt == dn0 && n < 2000) begin
            if (noise) begin
                start  = ($urandom_range(3, 0) == 0);
                digest = rand_digest();
            end
            step();
            n++;
        end
        start = 1'b0;
        wait_done(dn0 + 1, 1, name);
        finish_frames(dv0, dn0, 1, name);
    endtask

    task automatic test_reset();
        digest = rand_digest();
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b required 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: done=%b required 0", done); end
        checks++;
        if (tx_dv !== 1'b0) begin errors++; $display("FAIL reset_dv: dv=%b required 0", tx_dv); end
        checks++;
        if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: byte=%h required 00", tx_byte); end
        mon_en = 1'b1;
        rst    = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (dv_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: dv=%0d busy=%b required 0 0", dv_cnt, busy);
        end
    endtask

    task automatic test_latency();
        logic [DW-1:0] d;
        int dv0 = dv_cnt;
        int dn0 = done_cnt;
        d = rand_digest();
        push_frame(d);
        digest = d;
        start  = 1'b1;
        step();
        start  = 1'b0;
        digest = ~d;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy: busy=%b required 1", busy); end
        checks++;
        if (tx_dv !== 1'b0) begin errors++; $display("FAIL latency_early_dv: dv=%b required 0", tx_dv); end
        step();
        checks++;
        if (tx_dv !== 1'b1) begin errors++; $display("FAIL latency_first_dv: dv=%b required 1", tx_dv); end
        wait_done(dn0 + 1, 2000, "latency");
        finish_frames(dv0, dn0, 1, "latency");
    endtask

    task automatic test_frame_ascending();
        logic [DW-1:0] d;
        for (int i = 0; i < NB; i++) d[(NB-1-i)*8 +: 8] = 8'(i);
        act_min = 1; act_max = 6; done_min = 1; done_max = 3;
        run_frame(d, 1'b0, "ascending");
    endtask

    task automatic test_checksum();
        logic [DW-1:0] d;
        d = '0;
        d[DW-1 -: 8] = 8'h5A;
        run_frame(d, 1'b0, "checksum");
    endtask

    task automatic test_gap();
        act_min = 2; act_max = 2; done_min = 1; done_max = 1;
        gap_chk = 1'b1;
        run_frame(rand_digest(), 1'b0, "gap");
        gap_chk = 1'b0;
    endtask

    task automatic test_ignore_start();
        act_min = 1; act_max = 4; done_min = 1; done_max = 3;
        run_frame(rand_digest(), 1'b1, "ignore_start");
        run_frame(rand_digest(), 1'b1, "ignore_start2");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            act_min = 1;
            act_max = $urandom_range(8, 1);
            done_min = 1;
            done_max = $urandom_range(3, 1);
            run_frame(rand_digest(), k[0], "random");
        end
    endtask

    task automatic test_reset_mid();
        int dv0 = dv_cnt;
        int dn0 = done_cnt;
        int n = 0;
        act_min = 4; act_max = 4; done_min = 1; done_max = 3;
        push_frame(rand_digest());
        digest = rand_digest();
        exp_q.delete();
        push_frame(digest);
        start = 1'b1;
        step();
        start = 1'b0;
        while (dv_cnt < dv0 + 6 && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (dv_cnt != dv0 + 6) begin
            errors++;
            $display("FAIL reset_mid_reach6: dv=%0d required %0d", dv_cnt - dv0, 6);
        end
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || tx_dv !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b dv=%b required 0 0", busy, tx_dv);
        end
        digest = rand_digest();
        push_frame(digest);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(dn0 + 1, 2000, "reset_mid");
        finish_frames(dv0 + 6, dn0, 1, "reset_mid");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        int dv0 = dv_cnt;
        int dn0 = done_cnt;
        int n = 0;
        act_min = 1; act_max = 2; done_min = 3; done_max = 3;
        d = rand_digest();
        for (int k = 0; k < 3; k++) push_frame(d);
        digest = d;
        start  = 1'b1;
        while (done_cnt < dn0 + 3 && n < 5000) begin
            step();
            n++;
        end
        start = 1'b0;
        wait_done(dn0 + 3, 1, "back_to_back");
        finish_frames(dv0, dn0, 3, "back_to_back");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frame_ascending();
        test_checksum();
        test_gap();
        test_ignore_start();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
